// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined ALU among NREQ requesters.
// Winner operands are registered onto the ALU bus; an in-order tag FIFO routes results back.
module alu_issue_arbiter #(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int MAXOUT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ*4-1:0]     req_op_i,
  output logic [WIDTH-1:0]      alu_a_o,
  output logic [WIDTH-1:0]      alu_b_o,
  output logic [3:0]            alu_op_o,
  output logic                  alu_valid_in_o,
  input  logic [WIDTH-1:0]      alu_result_i,
  input  logic                  alu_zero_i,
  input  logic                  alu_overflow_i,
  input  logic                  alu_valid_out_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]      rsp_result_o,
  output logic                  rsp_zero_o,
  output logic                  rsp_overflow_o,
  output logic                  err_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(MAXOUT);
  localparam int CW = $clog2(MAXOUT + 1);

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [IW-1:0]    tagMem_q [MAXOUT];
  logic [IW-1:0]    grantIdx, scanIdx;
  logic [NREQ-1:0]  grantVec;
  logic             found, canIssue, push, pop, popEmpty;
  int               scan;

  logic [WIDTH-1:0] aluA_q, aluB_q;
  logic [3:0]       aluOp_q;
  logic             aluValidIn_q;
  logic [NREQ-1:0]  rspValid_q;
  logic [WIDTH-1:0] rspResult_q;
  logic             rspZero_q, rspOverflow_q, err_q;

  assign pop      = alu_valid_out_i & (count_q != '0);
  assign popEmpty = alu_valid_out_i & (count_q == '0);
  assign canIssue = (count_q < CW'(MAXOUT)) | pop;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    scan     = 0;
    scanIdx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan    = (int'(ptr_q) + k) % NREQ;
      scanIdx = IW'(scan);
      if (!found && req_valid_i[scanIdx]) begin
        found    = 1'b1;
        grantIdx = scanIdx;
      end
    end
  end

  assign push = found & canIssue & ~rst_i;

  always_comb begin
    grantVec = '0;
    if (push) grantVec[grantIdx] = 1'b1;
  end

  assign req_ready_o = grantVec;

  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      if (grantIdx == IW'(NREQ - 1)) ptr_d = '0;
      else                           ptr_d = grantIdx + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q         <= '0;
      count_q       <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      aluA_q        <= '0;
      aluB_q        <= '0;
      aluOp_q       <= '0;
      aluValidIn_q  <= 1'b0;
      rspValid_q    <= '0;
      rspResult_q   <= '0;
      rspZero_q     <= 1'b0;
      rspOverflow_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      aluValidIn_q <= push;
      if (push) begin
        aluA_q  <= req_a_i[grantIdx*WIDTH +: WIDTH];
        aluB_q  <= req_b_i[grantIdx*WIDTH +: WIDTH];
        aluOp_q <= req_op_i[grantIdx*4 +: 4];
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      // A result with no outstanding tag is dropped and flagged, never routed.
      if (pop) begin
        rspValid_q    <= NREQ'(1) << tagMem_q[rdPtr_q];
        rspResult_q   <= alu_result_i;
        rspZero_q     <= alu_zero_i;
        rspOverflow_q <= alu_overflow_i;
        rdPtr_q       <= rdPtr_q + 1'b1;
      end else begin
        rspValid_q <= '0;
      end
      if (popEmpty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tagMem_q[wrPtr_q] <= grantIdx;
  end

  assign alu_a_o        = aluA_q;
  assign alu_b_o        = aluB_q;
  assign alu_op_o       = aluOp_q;
  assign alu_valid_in_o = aluValidIn_q;
  assign rsp_valid_o    = rspValid_q;
  assign rsp_result_o   = rspResult_q;
  assign rsp_zero_o     = rspZero_q;
  assign rsp_overflow_o = rspOverflow_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter driving a 2-cycle stand-in ALU with freeze and
// spurious-output controls; a negedge monitor compares every response against the queue.
module tb_alu_issue_arbiter;
  localparam int WIDTH  = 8;
  localparam int NREQ   = 4;
  localparam int MAXOUT = 4;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       zero;
    logic       ovf;
  } expT;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       reqValid, reqReady;
  logic [NREQ*WIDTH-1:0] reqA, reqB;
  logic [NREQ*4-1:0]     reqOp;
  logic [WIDTH-1:0]      aluA, aluB, aluResult;
  logic [3:0]            aluOp;
  logic                  aluValidIn, aluZero, aluOvf, aluValidOut;
  logic [NREQ-1:0]       rspValid;
  logic [WIDTH-1:0]      rspResult;
  logic                  rspZero, rspOvf, err;

  expT        sbQ[$];
  int         checks = 0;
  int         errors = 0;
  logic       freezeAlu = 1'b0;
  logic       forceSpurious = 1'b0;
  logic       s1V, s1Ovf;
  logic [7:0] s1Res;
  logic [8:0] holdQ[$];
  logic [8:0] popTmp;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAXOUT(MAXOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .req_a_i(reqA), .req_b_i(reqB), .req_op_i(reqOp),
    .alu_a_o(aluA), .alu_b_o(aluB), .alu_op_o(aluOp), .alu_valid_in_o(aluValidIn),
    .alu_result_i(aluResult), .alu_zero_i(aluZero), .alu_overflow_i(aluOvf),
    .alu_valid_out_i(aluValidOut),
    .rsp_valid_o(rspValid), .rsp_result_o(rspResult), .rsp_zero_o(rspZero),
    .rsp_overflow_o(rspOvf), .err_o(err)
  );

  function automatic logic [8:0] aluCompute(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [8:0] r;
    r = '0;
    case (op)
      4'h0: begin r[7:0] = a + b; r[8] = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h1: begin r[7:0] = a - b; r[8] = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h2: r[7:0] = a & b;
      4'h3: r[7:0] = a | b;
      4'h4: r[7:0] = a ^ b;
      4'h5: r[7:0] = a << 1;
      4'h6: r[7:0] = a >> 1;
      4'h7: r[7:0] = ~a;
      4'h8: r[7:0] = b;
      4'h9: r[7:0] = a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stand-in ALU: one compute stage, then an output stage that can be frozen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1V         <= 1'b0;
      s1Res       <= '0;
      s1Ovf       <= 1'b0;
      aluValidOut <= 1'b0;
      aluResult   <= '0;
      aluZero     <= 1'b0;
      aluOvf      <= 1'b0;
      holdQ.delete();
    end else begin
      if (s1V) holdQ.push_back({s1Ovf, s1Res});
      s1V            <= aluValidIn;
      {s1Ovf, s1Res} <= aluCompute(aluA, aluB, aluOp);
      if (forceSpurious) begin
        aluValidOut <= 1'b1;
        aluResult   <= 8'h00;
        aluZero     <= 1'b1;
        aluOvf      <= 1'b0;
      end else if (!freezeAlu && holdQ.size() > 0) begin
        popTmp      = holdQ.pop_front();
        aluValidOut <= 1'b1;
        aluResult   <= popTmp[7:0];
        aluZero     <= (popTmp[7:0] == 8'h00);
        aluOvf      <= popTmp[8];
      end else begin
        aluValidOut <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op);
    reqA[id*WIDTH +: WIDTH] = a;
    reqB[id*WIDTH +: WIDTH] = b;
    reqOp[id*4 +: 4]        = op;
    reqValid[id]            = 1'b1;
  endtask

  task automatic expectRsp(input int id, input logic [7:0] res, input logic zero,
                           input logic ovf);
    expT e;
    e.id = id; e.res = res; e.zero = zero; e.ovf = ovf;
    sbQ.push_back(e);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    reqValid = '0;
    sbQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, sbQ.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Every response strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    expT e;
    if (!rst && rspValid != '0) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRsp actual rsp_valid=%b expected none", rspValid);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rspValid", 32'(rspValid), 32'(1 << e.id));
        checkOutput("rspResult", 32'(rspResult), 32'(e.res));
        checkOutput("rspZero", 32'(rspZero), 32'(e.zero));
        checkOutput("rspOverflow", 32'(rspOvf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int order[5];
    int issues;
    rst      = 1'b1;
    reqValid = 4'b1111;
    reqA     = '0;
    reqB     = '0;
    reqOp    = '0;
    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rstReady", 32'(reqReady), 0);
    checkOutput("rstAluValidIn", 32'(aluValidIn), 0);
    checkOutput("rstAluA", 32'(aluA), 0);
    checkOutput("rstRspValid", 32'(rspValid), 0);
    checkOutput("rstErr", 32'(err), 0);
    reqValid = '0;
    rst      = 1'b0;

    $display("[TB] single requester");
    @(negedge clk);
    applyStimulus(2, 8'h05, 8'h03, 4'h0);
    expectRsp(2, 8'h08, 1'b0, 1'b0);
    #1 checkOutput("singleGrant", 32'(reqReady), 32'b0100);
    @(posedge clk);
    #1 reqValid[2] = 1'b0;
    @(negedge clk);
    checkOutput("singleValidIn", 32'(aluValidIn), 1);
    checkOutput("singleAluA", 32'(aluA), 32'h05);
    checkOutput("singleAluB", 32'(aluB), 32'h03);
    checkOutput("singleAluOp", 32'(aluOp), 0);
    @(negedge clk);
    checkOutput("singleValidInDrop", 32'(aluValidIn), 0);
    repeat (2) @(negedge clk);
    checkOutput("singleRspLatency", 32'(rspValid), 32'b0100);
    waitDrain("singleDrain");

    $display("[TB] round robin");
    doReset();
    applyStimulus(0, 8'h01, 8'h01, 4'h0);
    applyStimulus(1, 8'h09, 8'h09, 4'h1);
    applyStimulus(2, 8'hAA, 8'h55, 4'h4);
    applyStimulus(3, 8'hDE, 8'h00, 4'h9);
    expectRsp(0, 8'h02, 1'b0, 1'b0);
    expectRsp(1, 8'h00, 1'b1, 1'b0);
    expectRsp(2, 8'hFF, 1'b0, 1'b0);
    expectRsp(3, 8'hDE, 1'b0, 1'b0);
    expectRsp(0, 8'h02, 1'b0, 1'b0);
    order = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      #1 checkOutput("rrGrant", 32'(reqReady), 32'(1 << order[g]));
      @(posedge clk);
      #1 if (order[g] != 0 || g == 4) reqValid[order[g]] = 1'b0;
      @(negedge clk);
    end
    waitDrain("rrDrain");

    $display("[TB] full fifo");
    doReset();
    freezeAlu = 1'b1;
    applyStimulus(0, 8'h01, 8'h02, 4'h0);
    applyStimulus(1, 8'h03, 8'h04, 4'h0);
    expectRsp(0, 8'h03, 1'b0, 1'b0);
    expectRsp(1, 8'h07, 1'b0, 1'b0);
    expectRsp(0, 8'h03, 1'b0, 1'b0);
    expectRsp(1, 8'h07, 1'b0, 1'b0);
    expectRsp(0, 8'h03, 1'b0, 1'b0);
    issues = 0;
    repeat (8) begin
      #1 if ((reqReady & reqValid) != '0) issues++;
      @(negedge clk);
    end
    checkOutput("fullIssues", 32'(issues), 4);
    checkOutput("fullReady", 32'(reqReady), 0);
    freezeAlu = 1'b0;
    @(posedge clk);
    #1 freezeAlu = 1'b1;
    @(negedge clk);
    checkOutput("fullPopGrant", 32'(reqReady), 32'b0001);
    @(negedge clk);
    checkOutput("fullStaysFull", 32'(reqReady), 0);
    reqValid  = '0;
    freezeAlu = 1'b0;
    waitDrain("fullDrain");

    $display("[TB] spurious alu output");
    doReset();
    forceSpurious = 1'b1;
    @(posedge clk);
    #1 forceSpurious = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("spurErr", 32'(err), 1);
    checkOutput("spurNoRsp", 32'(rspValid), 0);
    applyStimulus(1, 8'h10, 8'h01, 4'h1);
    expectRsp(1, 8'h0F, 1'b0, 1'b0);
    @(posedge clk);
    #1 reqValid[1] = 1'b0;
    waitDrain("spurDrain");
    checkOutput("spurErrSticky", 32'(err), 1);

    $display("[TB] reset mid-flight");
    doReset();
    applyStimulus(0, 8'h11, 8'h22, 4'h0);
    applyStimulus(1, 8'h33, 8'h01, 4'h1);
    applyStimulus(2, 8'h0F, 8'hF0, 4'h3);
    @(posedge clk);
    #1 reqValid[0] = 1'b0;
    @(posedge clk);
    #1 reqValid[1] = 1'b0;
    @(posedge clk);
    #1 reqValid[2] = 1'b0;
    rst = 1'b1;
    applyStimulus(3, 8'hF0, 8'h3C, 4'h2);
    repeat (2) @(negedge clk);
    checkOutput("midRstReady", 32'(reqReady), 0);
    checkOutput("midRstValidIn", 32'(aluValidIn), 0);
    checkOutput("midRstAluA", 32'(aluA), 0);
    checkOutput("midRstAluB", 32'(aluB), 0);
    checkOutput("midRstAluOp", 32'(aluOp), 0);
    checkOutput("midRstRspValid", 32'(rspValid), 0);
    checkOutput("midRstErr", 32'(err), 0);
    rst = 1'b0;
    applyStimulus(1, 8'h01, 8'h01, 4'h0);
    #1 checkOutput("midRstPtrZero", 32'(reqReady), 32'b0010);
    reqValid[1] = 1'b0;
    expectRsp(3, 8'h30, 1'b0, 1'b0);
    #1 checkOutput("midRstGrant3", 32'(reqReady), 32'b1000);
    @(posedge clk);
    #1 reqValid[3] = 1'b0;
    waitDrain("midRstDrain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Round-robin arbiter that shares one pipelined `alu_optimized` instance among `NREQ` requesters. Each requester gets a valid/ready issue port. The block registers the winning operands onto the ALU input bus and tracks requester IDs in an in-order tag FIFO. It routes each ALU result back to the requester that issued it. It sits between the requesters and the ALU, and drives the ALU's `valid_in` and operand ports directly.

## Interface
- `WIDTH`, 8: operand/result width; must match the ALU.
- `NREQ`, 4: number of requesters, 2..8.
- `MAXOUT`, 4: maximum in-flight operations (tag FIFO depth), power of two, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset; shared with the ALU.
- `req_valid` in NREQ: requester i has an operation pending.
- `req_ready` out NREQ: one-hot grant; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_a` in NREQ*WIDTH: operand A; requester i at `[i*WIDTH +: WIDTH]`.
- `req_b` in NREQ*WIDTH: operand B, same packing.
- `req_op` in NREQ*4: opcode; requester i at `[i*4 +: 4]`; passed through unchanged (ALU op encoding 0x0–0x9).
- `alu_a`, `alu_b` out WIDTH: registered operands to the ALU.
- `alu_op` out 4: registered opcode.
- `alu_valid_in` out 1: one-cycle issue strobe.
- `alu_result` in WIDTH, `alu_zero` in 1, `alu_overflow` in 1, `alu_valid_out` in 1: ALU outputs; results are in order, latency unspecified.
- `rsp_valid` out NREQ: one-hot, one-cycle response strobe to the owning requester.
- `rsp_result` out WIDTH, `rsp_zero` out 1, `rsp_overflow` out 1: registered result fields; valid only with `rsp_valid`.
- `err` out 1: sticky; set when `alu_valid_out` arrives with an empty tag FIFO.

## Operation
- **Grant (combinational):**
  - `can_issue = (count < MAXOUT) | (alu_valid_out & count != 0)`.
  - If `can_issue`, `req_ready` is the first requester with `req_valid` set, searching from `ptr` upward, modulo NREQ.
  - Otherwise `req_ready = 0`.
  - `req_ready` depends only on `req_valid`, `ptr`, `count` and `alu_valid_out`, never on operand values.
- **Pointer:** on a handshake with requester i, `ptr <= (i+1) mod NREQ`. With no handshake, `ptr` holds.
- **Issue:**
  - On a handshake, the next edge loads `alu_a/alu_b/alu_op` from requester i, pulses `alu_valid_in=1` for one cycle, and pushes i into the tag FIFO.
  - With no handshake, `alu_valid_in=0` and the operand registers hold their last values.
- **Return:**
  - On `alu_valid_out`, pop the FIFO head t. The next edge sets `rsp_valid[t]=1` and registers `alu_result/zero/overflow` into `rsp_*`.
  - On the following cycle `rsp_valid` returns to 0 unless another pop occurred.
- **Simultaneous push and pop:** both take effect and `count` is unchanged. This is legal at `count==MAXOUT`.
- **Pop on empty:** `err<=1`, no response is generated, and `count` stays 0. `err` clears only on `rst`.
- **Responses:** there is no response backpressure; requesters must accept `rsp_valid` in any cycle.
- **Reset:**
  - Asserting `rst` at any time clears `ptr=0`, `count=0`, FIFO pointers, `alu_valid_in=0`, `alu_a/alu_b/alu_op=0`, `rsp_valid=0`, `rsp_*=0`, `err=0`.
  - `req_ready=0` while `rst` is high.
  - In-flight operations are discarded; the ALU pipeline is cleared by the same `rst`.

## Timing
- **Issue latency:** handshake sampled at edge k gives `alu_valid_in` high in cycle k..k+1.
- **Throughput:** one issue per cycle sustained while `count<MAXOUT` or a pop coincides.
- **Response latency:** `alu_valid_out` sampled at edge m gives `rsp_valid` high for exactly cycle m..m+1.
- **End-to-end:** end-to-end latency = ALU latency + 2 cycles.
- **Tag FIFO:** wraps modulo MAXOUT. `count` ranges 0..MAXOUT and never exceeds MAXOUT.
- **Requester obligations:** a requester holds `req_valid` and its operands stable until its handshake. Deasserting before grant is allowed and results in no issue.

## Test plan
- **Single requester:** reset, then requester 2 issues a=0x05, b=0x03, op=0x0. Required: `alu_valid_in` one cycle with alu_a=0x05, alu_b=0x03. `rsp_valid=4'b0100`, `rsp_result=0x08`, `rsp_zero=0` arrive ALU-latency+2 cycles after the handshake.
- **Round-robin fairness:** all four requesters hold `req_valid` with distinct ops (ADD 1+1, SUB 9-9, XOR 0xAA^0x55, PASS 0xDE).
  - Required: grants in order 0,1,2,3,0.
  - `rsp_valid` order 0,1,2,3 with results 0x02, 0x00 (zero=1), 0xFF, 0xDE.
- **Full FIFO:** freeze `alu_valid_out` low (MAXOUT=4) while requesters 0 and 1 stream.
  - Required: exactly 4 issues, then `req_ready=0`.
  - The first `alu_valid_out` pulse produces a grant that same cycle; `count` stays 4.
- **Spurious ALU output:** pulse `alu_valid_out` after reset with no issue. Required: `err=1` and stays 1; no `rsp_valid`; a later normal transaction still completes correctly.
- **Reset mid-flight:** issue 3 ops, assert `rst` for 2 cycles before any return. Required: all outputs at reset values, `err=0`, `ptr=0`. The next request from requester 3 is granted and returns to requester 3.
